// File: rtl/lc3_regfile_wr_arbiter.sv
`timescale 1ns/1ps
// lc3_regfile_wr_arbiter
// Shares the single LC-3 register file write port among three requesters:
// datapath writeback (DP), interrupt/trap controller (IRQ) and debug (DBG).
// Fixed priority DP > IRQ > DBG. A starvation limiter bounds the number of
// back-to-back DP grants while others wait. IRQ can lock the port so that
// multi-register saves (R6 then R7) go out without interleaving.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   dp_req/addr/data, dp_gnt     datapath writeback request, grant
//   irq_req/lock/addr/data,      interrupt controller request (lock keeps
//   irq_gnt                      ownership for the next IRQ write), grant
//   dbg_req/addr/data, dbg_gnt   debug port request, grant
//   LDREG, DR, wr_data           registered register-file write interface
//   locked                       arbiter is holding the port for IRQ
//   owner                        last granted requester (0 DP, 1 IRQ, 2 DBG)
module lc3_regfile_wr_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dp_req,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_data,
  output logic              dp_gnt,
  input  logic              irq_req,
  input  logic              irq_lock,
  input  logic [ADDR_W-1:0] irq_addr,
  input  logic [DATA_W-1:0] irq_data,
  output logic              irq_gnt,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_gnt,
  output logic              LDREG,
  output logic [ADDR_W-1:0] DR,
  output logic [DATA_W-1:0] wr_data,
  output logic              locked,
  output logic [1:0]        owner
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    ARB,
    LOCKED
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             others_pending;
  logic             dp_masked;

  assign others_pending = irq_req | dbg_req;
  // DP steps aside for one cycle once it has won LIMIT times in a row
  // while someone else was waiting.
  assign dp_masked      = others_pending && (starve_cnt == LIMIT);
  assign locked         = (state == LOCKED);

  // Grant selection and next-state logic. Grants are purely combinational
  // so a requester sees its grant in the same cycle it asks. Reset blocks
  // every grant so nothing can be accepted and then lost by the reset.
  // The counter can never exceed LIMIT because DP is masked at LIMIT.
  always_comb begin
    dp_gnt         = 1'b0;
    irq_gnt        = 1'b0;
    dbg_gnt        = 1'b0;
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    if (!rst) begin
      case (state)
        ARB: begin
          if (dp_req && !dp_masked) begin
            dp_gnt         = 1'b1;
            starve_cnt_nxt = others_pending ? (starve_cnt + CNT_W'(1)) : '0;
          end else if (irq_req) begin
            irq_gnt        = 1'b1;
            starve_cnt_nxt = '0;
            if (irq_lock) begin
              state_nxt = LOCKED;
            end
          end else if (dbg_req) begin
            dbg_gnt        = 1'b1;
            starve_cnt_nxt = '0;
          end else begin
            starve_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          // Only IRQ may write; dropping irq_req abandons the sequence.
          if (irq_req) begin
            irq_gnt = 1'b1;
            if (!irq_lock) begin
              state_nxt = ARB;
            end
          end else begin
            state_nxt = ARB;
          end
        end
        default: begin
          state_nxt = ARB;
        end
      endcase
    end
  end

  // State, starvation counter and the registered write port. Each grant
  // becomes exactly one LDREG pulse on the following edge; without a grant
  // DR and wr_data keep their last values so the bus stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      starve_cnt <= '0;
      LDREG      <= 1'b0;
      DR         <= '0;
      wr_data    <= '0;
      owner      <= 2'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      LDREG      <= dp_gnt | irq_gnt | dbg_gnt;
      if (dp_gnt) begin
        DR      <= dp_addr;
        wr_data <= dp_data;
        owner   <= 2'd0;
      end else if (irq_gnt) begin
        DR      <= irq_addr;
        wr_data <= irq_data;
        owner   <= 2'd1;
      end else if (dbg_gnt) begin
        DR      <= dbg_addr;
        wr_data <= dbg_data;
        owner   <= 2'd2;
      end
    end
  end

endmodule
